// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - program counter generator with trap handling and return-address stack
// BOOT/RUN/TRAP sequencing, prioritised redirect, circular RAS that overwrites its oldest entry.
module pc_gen #(
   parameter int unsigned      WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
   parameter int unsigned      RAS_DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PCWrite,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             call,
   input  logic             ret,
   input  logic             exception,
   input  logic             eret,
   output logic [WIDTH-1:0] currentAddress,
   output logic [WIDTH-1:0] epc,
   output logic             pc_valid,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_underflow
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

   typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d, epc_q, epc_d;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [PW-1:0]    sp_q;
   logic [CW-1:0]    cnt_q;
   logic             uflow_q, uflow_d;
   logic             push, pop, repl;
   logic [WIDTH-1:0] seq_pc, ras_top;
   logic             empty, full;

   assign seq_pc  = pc_q + FOUR;
   assign ras_top = ras_q[sp_q - PW'(1)];
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(RAS_DEPTH));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      uflow_d = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      repl    = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         TRAP: state_d = RUN;
         RUN: begin
            if (exception) begin
               epc_d   = pc_q;
               pc_d    = EXC_VECTOR;
               state_d = TRAP;
            end else if (eret) begin
               pc_d = epc_q;
            end else if (PCWrite) begin
               if (ret) begin
                  // Empty-stack return falls through to the next sequential address.
                  if (empty) begin
                     pc_d    = seq_pc;
                     uflow_d = 1'b1;
                     push    = call;
                  end else begin
                     pc_d = ras_top;
                     repl = call;
                     pop  = ~call;
                  end
               end else begin
                  if (jump)              pc_d = jump_target;
                  else if (branch_taken) pc_d = branch_target;
                  else                   pc_d = seq_pc;
                  push = call;
               end
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         epc_q   <= '0;
         uflow_q <= 1'b0;
         sp_q    <= '0;
         cnt_q   <= '0;
         for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         uflow_q <= uflow_d;
         if (push) begin
            ras_q[sp_q] <= seq_pc;
            sp_q        <= sp_q + PW'(1);
            if (!full) cnt_q <= cnt_q + CW'(1);
         end else if (pop) begin
            sp_q  <= sp_q - PW'(1);
            cnt_q <= cnt_q - CW'(1);
         end else if (repl) begin
            ras_q[sp_q - PW'(1)] <= seq_pc;
         end
      end
   end

   assign currentAddress = pc_q;
   assign epc            = epc_q;
   assign pc_valid       = (state_q == RUN);
   assign ras_empty      = empty;
   assign ras_full       = full;
   assign ras_underflow  = uflow_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen
// Queue-based reference model checked every negedge, plus literal checks on directed vectors.
module tb_pc_gen;

   logic        clk = 1'b0, rst_n = 1'b1;
   logic        pcw = 0, br = 0, jmp = 0, call = 0, ret = 0, exc = 0, eret = 0;
   logic [31:0] bt = '0, jt = '0;
   logic [31:0] pc, epc;
   logic        pv, re, rf, ru;

   logic        rst8 = 1'b1, pcw8 = 1'b0, jmp8 = 1'b0, zero = 1'b0;
   logic [7:0]  jt8 = '0, z8 = '0;
   logic [7:0]  pc8, epc8;
   logic        pv8, re8, rf8, ru8;

   int checks = 0, errors = 0;

   pc_gen dut (
      .clk(clk), .reset(rst_n), .PCWrite(pcw),
      .branch_taken(br), .branch_target(bt), .jump(jmp), .jump_target(jt),
      .call(call), .ret(ret), .exception(exc), .eret(eret),
      .currentAddress(pc), .epc(epc), .pc_valid(pv),
      .ras_empty(re), .ras_full(rf), .ras_underflow(ru)
   );

   pc_gen #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst8), .PCWrite(pcw8),
      .branch_taken(zero), .branch_target(z8), .jump(jmp8), .jump_target(jt8),
      .call(zero), .ret(zero), .exception(zero), .eret(zero),
      .currentAddress(pc8), .epc(epc8), .pc_valid(pv8),
      .ras_empty(re8), .ras_full(rf8), .ras_underflow(ru8)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: m_run=0 covers both the boot and trap cycles, each lasting one edge.
   logic [31:0] m_pc = '0, m_epc = '0;
   logic        m_run = 1'b0, m_uf = 1'b0;
   logic [31:0] m_ras[$];

   always @(posedge clk or negedge rst_n) begin
      logic [31:0] seq, nxt;
      if (!rst_n) begin
         m_pc = '0; m_epc = '0; m_run = 1'b0; m_uf = 1'b0;
         m_ras.delete();
      end else begin
         seq  = m_pc + 32'd4;
         m_uf = 1'b0;
         if (!m_run) m_run = 1'b1;
         else if (exc) begin
            m_epc = m_pc; m_pc = 32'h80; m_run = 1'b0;
         end else if (eret) m_pc = m_epc;
         else if (pcw) begin
            if (ret) begin
               if (m_ras.size() == 0) begin nxt = seq; m_uf = 1'b1; end
               else nxt = m_ras.pop_back();
            end else if (jmp) nxt = jt;
            else if (br) nxt = bt;
            else nxt = seq;
            if (call) begin
               m_ras.push_back(seq);
               if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            m_pc = nxt;
         end
      end
   end

   always @(negedge clk) begin
      check("pc", pc, m_pc);
      check("epc", epc, m_epc);
      check("pc_valid", {31'd0, pv}, {31'd0, m_run});
      check("ras_empty", {31'd0, re}, {31'd0, m_ras.size() == 0});
      check("ras_full", {31'd0, rf}, {31'd0, m_ras.size() == 4});
      check("ras_underflow", {31'd0, ru}, {31'd0, m_uf});
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_ret [4];
      exp_ret[0] = 32'h404; exp_ret[1] = 32'h304; exp_ret[2] = 32'h204; exp_ret[3] = 32'h104;

      #1 rst_n = 1'b0; rst8 = 1'b0;
      tick(); tick();
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'd0, pv}, 32'd0);
      check("rst_empty", {31'd0, re}, 32'd1);
      check("rst_full", {31'd0, rf}, 32'd0);

      rst_n = 1'b1; pcw = 1'b1;
      tick(); check("boot_pc", pc, 32'h0); check("boot_valid", {31'd0, pv}, 32'd1);
      tick(); check("seq1", pc, 32'h4);
      tick(); check("seq2", pc, 32'h8);
      tick(); tick(); check("seq4", pc, 32'h10);

      pcw = 1'b0; exc = 1'b1;
      tick(); check("exc_epc", epc, 32'h10); check("exc_pc", pc, 32'h80);
      check("exc_valid", {31'd0, pv}, 32'd0);
      exc = 1'b0;
      tick(); check("trap_hold", pc, 32'h80); check("trap_exit", {31'd0, pv}, 32'd1);
      eret = 1'b1;
      tick(); check("eret_pc", pc, 32'h10); check("eret_epc", epc, 32'h10);
      eret = 1'b0;

      rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
      pcw = 1'b1; call = 1'b1; jmp = 1'b1;
      for (int i = 0; i < 5; i++) begin
         jt = 32'((i + 1) * 32'h100);
         tick();
         if (i == 2) check("not_full", {31'd0, rf}, 32'd0);
         if (i == 3) check("full_4", {31'd0, rf}, 32'd1);
      end
      check("call_pc", pc, 32'h500);
      call = 1'b0; jmp = 1'b0; ret = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ret_pc", pc, exp_ret[i]);
      end
      tick(); check("uflow_pc", pc, 32'h108); check("uflow_pulse", {31'd0, ru}, 32'd1);
      ret = 1'b0;
      tick(); check("uflow_clear", {31'd0, ru}, 32'd0); check("after_uflow", pc, 32'h10C);

      call = 1'b1; jmp = 1'b1; jt = 32'h200;
      tick(); check("call2", pc, 32'h200);
      call = 1'b0; ret = 1'b1; jt = 32'h300; br = 1'b1; bt = 32'h400;
      tick(); check("ret_prio", pc, 32'h110);
      ret = 1'b0; br = 1'b0; pcw = 1'b0; jt = 32'h500;
      tick(); check("stall", pc, 32'h110);

      pcw = 1'b1; call = 1'b1; jt = 32'h600;
      tick(); check("call3", pc, 32'h600);
      jmp = 1'b0; ret = 1'b1;
      tick(); check("callret_pc", pc, 32'h114); check("callret_cnt", {31'd0, re}, 32'd0);
      call = 1'b0;
      tick(); check("replaced_top", pc, 32'h604); check("empty_again", {31'd0, re}, 32'd1);

      ret = 1'b0; call = 1'b1; jmp = 1'b1; jt = 32'h800;
      tick();
      call = 1'b0; jmp = 1'b0; exc = 1'b1; ret = 1'b1;
      tick(); check("exc_over_ret", pc, 32'h80); check("no_pop", {31'd0, re}, 32'd0);
      exc = 1'b0; ret = 1'b0;
      tick(); eret = 1'b1;
      tick(); check("eret2", pc, 32'h800);
      eret = 1'b0; ret = 1'b1;
      tick(); check("kept_entry", pc, 32'h608);
      ret = 1'b0; br = 1'b1; bt = 32'h900;
      tick(); check("branch", pc, 32'h900);

      br = 1'b0; call = 1'b1; jmp = 1'b1; jt = 32'hA00;
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      check("async_pc", pc, 32'h0);
      check("async_empty", {31'd0, re}, 32'd1);
      check("async_valid", {31'd0, pv}, 32'd0);
      @(negedge clk); #1;
      call = 1'b0; jmp = 1'b0; rst_n = 1'b1;
      tick(); check("rel_pc0", pc, 32'h0);
      tick(); check("rel_pc4", pc, 32'h4);

      rst8 = 1'b1;
      tick();
      pcw8 = 1'b1; jmp8 = 1'b1; jt8 = 8'hFC;
      tick(); check("w8_fc", {24'd0, pc8}, 32'hFC);
      jmp8 = 1'b0;
      tick(); check("w8_wrap", {24'd0, pc8}, 32'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter WIDTH, default 32: address width in bits.
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0080: exception handler address.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, at least 2.
REQ-005 Ports: clk (in, 1) clock; reset (in, 1) reset. The block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-006 Port PCWrite (in, 1): advance enable; 0 means stall.
REQ-007 Port branch_taken (in, 1) and branch_target (in, WIDTH): conditional redirect.
REQ-008 Port jump (in, 1) and jump_target (in, WIDTH): unconditional redirect.
REQ-009 Port call (in, 1): push return address. Port ret (in, 1): pop RAS and redirect.
REQ-010 Port exception (in, 1): trap. Port eret (in, 1): return from trap.
REQ-011 Port currentAddress (out, WIDTH): current PC.
REQ-012 Port epc (out, WIDTH): saved exception PC.
REQ-013 Port pc_valid (out, 1): PC is fetchable.
REQ-014 Ports ras_empty (out, 1), ras_full (out, 1): stack status.
REQ-015 Port ras_underflow (out, 1): one-cycle pulse.

Function
REQ-016 State machine states: BOOT, RUN, TRAP.
- BOOT -> RUN after one cycle.
- RUN -> TRAP on exception.
- TRAP -> RUN after one cycle.
REQ-017 pc_valid SHALL be 0 in BOOT and TRAP, and 1 in RUN.
REQ-018 In RUN, the next PC SHALL be selected by strict priority, registered at the clock edge:
- exception -> EXC_VECTOR
- eret -> epc
- ret -> RAS top
- jump -> jump_target
- branch_taken -> branch_target
- otherwise currentAddress+4
REQ-019 exception and eret SHALL act regardless of PCWrite. All other sources, and the sequential +4, SHALL act only when PCWrite=1. When PCWrite=0, the PC SHALL hold.
REQ-020 On an accepted exception, epc SHALL capture currentAddress, PC SHALL load EXC_VECTOR, and the state SHALL become TRAP. In TRAP, PC and epc SHALL hold, and all inputs SHALL be ignored.
REQ-021 Sequential increment SHALL be modulo 2^WIDTH; all-ones minus 3 wraps to 0.
REQ-022 call with PCWrite=1 in RUN SHALL push currentAddress+4, and the redirect SHALL come from jump/branch per REQ-018.
REQ-023 Push on a full RAS SHALL overwrite the oldest entry (circular). ras_full stays 1, and the count saturates at RAS_DEPTH.
REQ-024 ret with PCWrite=1 SHALL pop the top entry, and the PC SHALL take the popped value.
REQ-025 ret on an empty RAS SHALL redirect to currentAddress+4, pulse ras_underflow for one cycle, and leave the stack unchanged.
REQ-026 call and ret in the same cycle SHALL redirect to the old top and replace the top with currentAddress+4; the count is unchanged. If the stack is empty, this case SHALL behave as underflow plus push.
REQ-027 A RAS pop or push SHALL NOT occur on a cycle where exception or eret wins, nor when PCWrite=0.
REQ-028 eret SHALL leave epc unchanged. exception and eret in the same cycle: exception wins.
REQ-029 Next-PC latency SHALL be one clock; no output SHALL depend combinationally on inputs.

Reset
REQ-030 While reset=0, the block SHALL asynchronously force:
- currentAddress=RESET_VECTOR, epc=0
- state=BOOT, pc_valid=0
- RAS count=0, ras_empty=1, ras_full=0, ras_underflow=0
REQ-031 Reset asserted mid-operation SHALL discard RAS contents and any in-flight redirect immediately, without waiting for clk.
REQ-032 After reset release, the first edge SHALL leave PC at RESET_VECTOR (BOOT->RUN), and the second edge with PCWrite=1 SHALL give RESET_VECTOR+4.

Verification
REQ-033 Release reset, hold PCWrite=1 for 4 edges -> PC 0,0,4,8; pc_valid rises after edge 1.
REQ-034 At PC=0x10, pulse exception with PCWrite=0 -> epc=0x10, PC=0x80, one cycle of pc_valid=0; later eret -> PC=0x10.
REQ-035 Issue 5 calls (jump_target 0x100) from PC 0x0,0x100,0x100,... then issue 5 rets -> first 4 rets return the newest 4 addresses; 5th ret gives PC+4 with ras_underflow=1; ras_full=1 after the 4th push.
REQ-036 Assert jump, branch_taken and ret together with a non-empty RAS -> PC equals the RAS top; hold PCWrite=0 with jump -> PC unchanged.
REQ-037 With WIDTH=8 and PC=0xFC, advance -> PC=0x00.
REQ-038 Assert reset between clock edges during a call -> outputs reach reset values before the next edge; ras_empty=1.
